// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// FSM state encoding, RISC-V load/store funct3 codes, timeout default.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: legality/alignment check, byte enables, store
// replication, load lane extraction. Purely combinational.
// in:  store, funct3, off (request); ld_funct3, ld_off (latched); wdata, rdata
// out: ok, be, wdata_rep, rdata_ext
module lsu_align
  import lsu_pkg::*;
#(
  parameter int addr_data_width = 32
) (
  input  logic                       store,
  input  logic [2:0]                 funct3,
  input  logic [1:0]                 off,
  input  logic [addr_data_width-1:0] wdata,
  input  logic [2:0]                 ld_funct3,
  input  logic [1:0]                 ld_off,
  input  logic [addr_data_width-1:0] rdata,
  output logic                       ok,
  output logic [3:0]                 be,
  output logic [addr_data_width-1:0] wdata_rep,
  output logic [addr_data_width-1:0] rdata_ext
);

  logic legal;
  logic mis;
  logic is_b;
  logic is_h;
  logic is_w;
  logic [addr_data_width-1:0] sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign is_b = (funct3[1:0] == 2'b00);
  assign is_h = (funct3[1:0] == 2'b01);
  assign is_w = (funct3[1:0] == 2'b10);

  always_comb begin
    legal = 1'b0;
    mis   = 1'b0;
    unique case (funct3)
      F3_B:  legal = 1'b1;
      F3_H: begin
        legal = 1'b1;
        mis   = off[0];
      end
      F3_W: begin
        legal = 1'b1;
        mis   = |off;
      end
      F3_BU: legal = !store;
      F3_HU: begin
        legal = !store;
        mis   = off[0];
      end
      default: legal = 1'b0;
    endcase
  end

  assign ok = legal && !mis;

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    unique case (1'b1)
      is_b: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
      end
      is_h: begin
        be        = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
      end
      is_w: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
  end

  assign sh     = rdata >> {ld_off, 3'b000};
  assign byte_v = sh[7:0];
  assign half_v = sh[15:0];

  always_comb begin
    rdata_ext = rdata;
    unique case (ld_funct3)
      F3_B:    rdata_ext = {{24{byte_v[7]}}, byte_v};
      F3_H:    rdata_ext = {{16{half_v[15]}}, half_v};
      F3_BU:   rdata_ext = {24'h0, byte_v};
      F3_HU:   rdata_ext = {16'h0, half_v};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: req/gnt/rvalid bus handshake with timeout.
// Datapath side: req_* in, lsu_stall/done/err/rdata out; bus side: mem_* .
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int addr_data_width = 32,
  parameter int TIMEOUT         = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       req_valid,
  input  logic                       req_store,
  input  logic [2:0]                 req_funct3,
  input  logic [addr_data_width-1:0] req_addr,
  input  logic [addr_data_width-1:0] req_wdata,
  output logic                       lsu_stall,
  output logic                       lsu_done,
  output logic                       lsu_err,
  output logic [addr_data_width-1:0] lsu_rdata,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [addr_data_width-1:0] mem_addr,
  output logic [3:0]                 mem_be,
  output logic [addr_data_width-1:0] mem_wdata,
  input  logic                       mem_gnt,
  input  logic                       mem_rvalid,
  input  logic [addr_data_width-1:0] mem_rdata
);

  lsu_state_t state_q;
  lsu_state_t state_d;
  logic [4:0] cnt_q;
  logic [4:0] cnt_d;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic       ok;
  logic       tmo;
  logic [3:0] be_c;
  logic [addr_data_width-1:0] wdata_c;
  logic [addr_data_width-1:0] rdata_ext;

  lsu_align #(
    .addr_data_width(addr_data_width)
  ) u_align (
    .store     (req_store),
    .funct3    (req_funct3),
    .off       (req_addr[1:0]),
    .wdata     (req_wdata),
    .ld_funct3 (f3_q),
    .ld_off    (off_q),
    .rdata     (mem_rdata),
    .ok        (ok),
    .be        (be_c),
    .wdata_rep (wdata_c),
    .rdata_ext (rdata_ext)
  );

  assign tmo = (cnt_q == 5'(TIMEOUT - 1));

  assign lsu_stall = (state_q == S_REQ) ||
                     (state_q == S_WAIT) ||
                     ((state_q == S_IDLE) && req_valid && ok);

  // A completing handshake wins over a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req_valid) state_d = ok ? S_REQ : S_ERR;
      end
      S_REQ: begin
        cnt_d = cnt_q + 5'd1;
        if (mem_gnt && mem_rvalid) state_d = S_DONE;
        else if (mem_gnt)          state_d = S_WAIT;
        else if (tmo)              state_d = S_ERR;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 5'd1;
        if (mem_rvalid) state_d = S_DONE;
        else if (tmo)   state_d = S_ERR;
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      S_ERR: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      lsu_done  <= 1'b0;
      lsu_err   <= 1'b0;
      lsu_rdata <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mem_req  <= (state_d == S_REQ);
      lsu_done <= (state_d == S_DONE);
      lsu_err  <= (state_d == S_ERR);
      if ((state_q == S_IDLE) && (state_d == S_REQ)) begin
        mem_we    <= req_store;
        mem_addr  <= {req_addr[addr_data_width-1:2], 2'b00};
        mem_be    <= be_c;
        mem_wdata <= wdata_c;
        f3_q      <= req_funct3;
        off_q     <= req_addr[1:0];
      end
      if (state_d == S_DONE) begin
        lsu_rdata <= mem_we ? '0 : rdata_ext;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit.
// Inputs driven 1ns after posedge, outputs sampled at negedge.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        lsu_stall;
  logic        lsu_done;
  logic        lsu_err;
  logic [31:0] lsu_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int n_chk = 0;
  int n_pass = 0;

  int          r_lat;
  int          r_reqcyc;
  int          r_stallcyc;
  logic        r_st0;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [3:0]  r_be;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_after;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .lsu_stall  (lsu_stall),
    .lsu_done   (lsu_done),
    .lsu_err    (lsu_err),
    .lsu_rdata  (lsu_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access; gnt arrives gd cycles into REQ, rvalid rdl cycles later.
  task automatic run(input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input int gd, input int rdl);
    tick();
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);
    r_st0      = lsu_stall;
    r_lat      = -1;
    r_reqcyc   = 0;
    r_stallcyc = 0;
    r_done     = 1'b0;
    r_err      = 1'b0;
    r_rdata    = 32'h0;
    r_be       = 4'h0;
    r_we       = 1'b0;
    r_addr     = 32'h0;
    r_wdata    = 32'h0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      req_valid  = 1'b0;
      mem_gnt    = (k == 1 + gd);
      mem_rvalid = (k == 1 + gd + rdl);
      mem_rdata  = mem_rvalid ? rd : 32'h0;
      @(negedge clk);
      if (lsu_stall) r_stallcyc++;
      if (mem_req) begin
        r_reqcyc++;
        r_be    = mem_be;
        r_we    = mem_we;
        r_addr  = mem_addr;
        r_wdata = mem_wdata;
      end
      if (lsu_done || lsu_err) begin
        r_lat   = k;
        r_done  = lsu_done;
        r_err   = lsu_err;
        r_rdata = lsu_rdata;
        break;
      end
    end
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk);
    r_after = {lsu_done, lsu_err, mem_req};
  endtask

  logic [6:0]  dpat;
  logic [31:0] rd2, rd5, a4, w4;
  logic        we1, we4;
  int          stray;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_stall", 32'(lsu_stall), 32'h0);
    check("rst_done", 32'(lsu_done), 32'h0);
    check("rst_err", 32'(lsu_err), 32'h0);
    check("rst_rdata", lsu_rdata, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_be", 32'(mem_be), 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_we", 32'(mem_we), 32'h0);
    tick();
    reset_n = 1'b1;

    // SW, zero-wait memory
    run(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0, 0);
    check("sw_st0", 32'(r_st0), 32'h1);
    check("sw_lat", 32'(r_lat), 32'd2);
    check("sw_done", 32'(r_done), 32'h1);
    check("sw_addr", r_addr, 32'h0000_0104);
    check("sw_be", 32'(r_be), 32'hF);
    check("sw_we", 32'(r_we), 32'h1);
    check("sw_wdata", r_wdata, 32'hDEAD_BEEF);
    check("sw_stallcyc", 32'(r_stallcyc), 32'd1);
    check("sw_rdata", r_rdata, 32'h0);
    check("sw_after", 32'(r_after), 32'h0);

    // LB with wait states
    run(1'b0, 3'b000, 32'h0000_0203, 32'h0, 32'h80FF_1234, 2, 3);
    check("lb_lat", 32'(r_lat), 32'd7);
    check("lb_be", 32'(r_be), 32'h8);
    check("lb_addr", r_addr, 32'h0000_0200);
    check("lb_we", 32'(r_we), 32'h0);
    check("lb_rdata", r_rdata, 32'hFFFF_FF80);
    check("lb_stallcyc", 32'(r_stallcyc), 32'd6);
    check("lb_reqcyc", 32'(r_reqcyc), 32'd3);

    run(1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'h80FF_1234, 2, 3);
    check("lbu_rdata", r_rdata, 32'h0000_0080);

    // SH lane replication
    run(1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 0, 1);
    check("sh_lat", 32'(r_lat), 32'd3);
    check("sh_be", 32'(r_be), 32'hC);
    check("sh_wdata", r_wdata, 32'hABCD_ABCD);

    // LH / LHU upper half
    run(1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 0, 0);
    check("lh_be", 32'(r_be), 32'hC);
    check("lh_rdata", r_rdata, 32'hFFFF_8001);
    run(1'b0, 3'b101, 32'h0000_0200, 32'h0, 32'h8001_FFFE, 1, 0);
    check("lhu_rdata", r_rdata, 32'h0000_FFFE);
    check("lhu_be", 32'(r_be), 32'h3);

    // Misaligned LH
    run(1'b0, 3'b001, 32'h0000_0101, 32'h0, 32'h0, 0, 0);
    check("mis_st0", 32'(r_st0), 32'h0);
    check("mis_lat", 32'(r_lat), 32'd1);
    check("mis_err", 32'(r_err), 32'h1);
    check("mis_reqcyc", 32'(r_reqcyc), 32'd0);

    // Illegal funct3: store with LBU code, load with 011
    run(1'b1, 3'b100, 32'h0000_0100, 32'h0, 32'h0, 0, 0);
    check("ill_st_err", 32'(r_err), 32'h1);
    check("ill_st_req", 32'(r_reqcyc), 32'd0);
    run(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0, 0);
    check("ill_ld_err", 32'(r_err), 32'h1);

    // Timeout: grant never comes
    run(1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h0, 1000, 0);
    check("tmo_err", 32'(r_err), 32'h1);
    check("tmo_lat", 32'(r_lat), 32'd17);
    check("tmo_reqcyc", 32'(r_reqcyc), 32'd16);
    check("tmo_after", 32'(r_after), 32'h0);

    // Back-to-back with req_valid held high
    dpat = '0;
    for (int c = 0; c <= 6; c++) begin
      tick();
      if (c == 0) begin
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0010;
        req_wdata  = 32'h0;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
      end
      if (c == 3) begin
        req_store = 1'b1;
        req_addr  = 32'h0000_0014;
        req_wdata = 32'h55AA_55AA;
      end
      if (c == 6) req_valid = 1'b0;
      @(negedge clk);
      dpat[c] = lsu_done;
      if (c == 1) we1 = mem_we;
      if (c == 2) rd2 = lsu_rdata;
      if (c == 4) begin
        we4 = mem_we;
        a4  = mem_addr;
        w4  = mem_wdata;
      end
      if (c == 5) rd5 = lsu_rdata;
    end
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    check("b2b_dpat", 32'(dpat), 32'h24);
    check("b2b_we1", 32'(we1), 32'h0);
    check("b2b_rd2", rd2, 32'hCAFE_F00D);
    check("b2b_we4", 32'(we4), 32'h1);
    check("b2b_a4", a4, 32'h0000_0014);
    check("b2b_w4", w4, 32'h55AA_55AA);
    check("b2b_rd5", rd5, 32'h0);

    // Reset while in REQ: mem_req drops asynchronously
    tick();
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0080;
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    check("rq_req", 32'(mem_req), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("rq_rst_req", 32'(mem_req), 32'h0);
    check("rq_rst_stall", 32'(lsu_stall), 32'h0);
    tick();
    reset_n = 1'b1;

    // Reset while in WAIT on a store
    tick();
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0300;
    req_wdata  = 32'h1122_3344;
    tick();
    req_valid = 1'b0;
    mem_gnt   = 1'b1;
    tick();
    mem_gnt = 1'b0;
    @(negedge clk);
    check("wt_stall", 32'(lsu_stall), 32'h1);
    check("wt_we", 32'(mem_we), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("wt_rst_we", 32'(mem_we), 32'h0);
    check("wt_rst_addr", mem_addr, 32'h0);
    check("wt_rst_be", 32'(mem_be), 32'h0);
    check("wt_rst_wdata", mem_wdata, 32'h0);
    check("wt_rst_stall", 32'(lsu_stall), 32'h0);
    check("wt_rst_pulse", 32'({lsu_done, lsu_err}), 32'h0);
    tick();
    reset_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hFFFF_FFFF;
      @(negedge clk);
      if (lsu_done || lsu_err || lsu_stall) stray++;
    end
    tick();
    mem_rvalid = 1'b0;
    check("stray_rvalid", 32'(stray), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit sitting directly downstream of the datapath's ALU, replacing the single-cycle data memory access with a request/grant/response handshake to a data memory bus. Takes the ALU-computed address, store data and funct3 from the datapath, performs byte-lane alignment, byte enables and load sign/zero extension, and stalls the datapath until the access completes, errors or times out.

## Interface
- addr_data_width, 32, address and data width; only 32 supported
- TIMEOUT, 16, max cycles from request to response before error
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  datapath has a memory instruction this cycle
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (size/sign)
- req_addr  in  addr_data_width  byte address from ALU
- req_wdata  in  addr_data_width  rs2 data
- lsu_stall  out  1  hold PC/pipeline
- lsu_done  out  1  one-cycle completion pulse
- lsu_err  out  1  one-cycle error pulse (misaligned, illegal funct3, timeout)
- lsu_rdata  out  addr_data_width  extended load result, valid with lsu_done
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  addr_data_width  word-aligned address, {req_addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  addr_data_width  lane-replicated store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  response (read data or write ack)
- mem_rdata  in  addr_data_width  read word

## Operation
- States: IDLE, REQ, WAIT, DONE, ERR.
- IDLE: on req_valid, check legality. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW; anything else illegal. Misaligned: half with addr[0]=1, word with addr[1:0]!=0. Illegal/misaligned -> ERR, no bus activity. Legal -> REQ, latch we/addr/be/wdata/funct3/offset.
- REQ: mem_req=1 with stable mem_we/addr/be/wdata until mem_gnt; on mem_gnt -> WAIT. If mem_gnt and mem_rvalid in same cycle -> DONE directly.
- WAIT: on mem_rvalid -> DONE; latch extended read data (stores: lsu_rdata=0).
- DONE: lsu_done=1, lsu_stall=0, req_valid ignored; -> IDLE next cycle.
- ERR: lsu_err=1, lsu_stall=0, req_valid ignored; -> IDLE next cycle.
- Timeout: 5-bit counter cleared on leaving IDLE, increments each cycle in REQ/WAIT; reaching TIMEOUT -> ERR, mem_req deasserted.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word as-is.
- Load extract: lane selected by latched offset; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.

## Timing
- lsu_stall = (state in REQ,WAIT) or (state==IDLE and req_valid and legal); combinational.
- All other outputs registered; reset value of every output 0, state IDLE, counter 0.
- Minimum latency: IDLE accept (cycle 0), REQ with gnt+rvalid (cycle 1), DONE (cycle 2); zero-wait memory: request seen cycle 0, done pulse cycle 2.
- Error latency: ERR pulse one cycle after req_valid in IDLE.
- Reset asserted mid-transaction: mem_req drops immediately (async), no done/err pulse; late mem_rvalid after reset ignored in IDLE.
- mem_rvalid in IDLE/DONE/ERR ignored.

## Structure
- Package lsu_pkg: state enum lsu_state_t, funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), TIMEOUT default.
- Sub-module lsu_align: combinational legality/misalign check, mem_be, store-lane replication and load extraction/extension; FSM and counter stay in load_store_unit.

## Test plan
- SW addr 0x0000_0104, wdata 0xDEADBEEF, gnt+rvalid same cycle -> mem_addr 0x104, mem_be 4'b1111, mem_we 1, lsu_done at cycle 2, stall high cycles 0-1.
- LB addr 0x203, mem_rdata 0x80FF_1234, gnt after 2 cycles, rvalid after 3 more -> mem_be 4'b1000, lsu_rdata 0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH addr 0x102, wdata 0x0000_ABCD -> mem_wdata 0xABCD_ABCD, mem_be 4'b1100; LH addr 0x101 -> lsu_err next cycle, mem_req never asserted.
- Load with mem_gnt never asserted -> lsu_err after TIMEOUT (16) cycles, mem_req low afterwards, return to IDLE.
- reset_n low while in WAIT -> all outputs 0 immediately; subsequent stray mem_rvalid produces no lsu_done.
- Back-to-back LW/SW with req_valid held high through DONE -> second request starts only after IDLE; exactly one done pulse per access.
